// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: board input and matrix drive bundle.
// master = game core / board side, slave = scanner.
interface led_matrix_scanner_if;
  logic         en;
  logic [127:0] field;
  logic [7:0]   row_sel;
  logic [7:0]   col_red;
  logic [7:0]   col_grn;
  logic         frame_start;

  modport master (
    output en,
    output field,
    input  row_sel,
    input  col_red,
    input  col_grn,
    input  frame_start
  );

  modport slave (
    input  en,
    input  field,
    output row_sel,
    output col_red,
    output col_grn,
    output frame_start
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: 8x8 bi-colour matrix row scanner with per-frame snapshot.
// Optional amber blink enabled by defining LMS_BLINK_EN.
module led_matrix_scanner #(
  parameter int ROW_CYCLES   = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  led_matrix_scanner_if.slave  bus
);

  localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(ROW_CYCLES - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [CW-1:0]  cnt;
  logic [2:0]     row;
  logic [127:0]   snap;
  logic           load_go;
  logic           mute_amber;

  logic [7:0]     row_d;
  logic [7:0]     red_d;
  logic [7:0]     grn_d;
  logic           fs_d;
  logic [1:0]     code;

  assign load_go = (state == LOAD) && bus.en;

`ifdef LMS_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt;
  logic          blink_phase;
  logic          frame_blink;

  // frame counter and blink phase; phase latched per frame at LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt        <= '0;
      blink_phase <= 1'b0;
      frame_blink <= 1'b0;
    end else if (load_go) begin
      frame_blink <= blink_phase;
      if (fcnt == FLAST) begin
        fcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign mute_amber = frame_blink;
`else
  assign mute_amber = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  // next-state: en low abandons the frame from any state
  always_comb begin
    state_n = state;
    unique case (state)
      LOAD: begin
        if (bus.en) state_n = BLANK;
      end
      BLANK: begin
        if (!bus.en)               state_n = LOAD;
        else if (cnt == BLANK_LAST) state_n = SHOW;
      end
      SHOW: begin
        if (!bus.en)
          state_n = LOAD;
        else if (cnt == SHOW_LAST)
          state_n = (row == 3'd7) ? LOAD : BLANK;
      end
      default: state_n = LOAD;
    endcase
  end

  // slot counter, row index and frame snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      row  <= '0;
      snap <= '0;
    end else begin
      if (state_n != state || state == LOAD) cnt <= '0;
      else                                   cnt <= cnt + CW'(1);
      if (state_n == LOAD)
        row <= '0;
      else if (state == SHOW && state_n == BLANK)
        row <= row + 3'd1;
      if (load_go) snap <= bus.field;
    end
  end

  // output decode from the state being entered, so drive tracks state
  always_comb begin
    row_d = '0;
    red_d = '0;
    grn_d = '0;
    code  = '0;
    fs_d  = load_go;
    if (state_n == SHOW) begin
      row_d = 8'd1 << row;
      for (int c = 0; c < 8; c++) begin
        code     = snap[{row, 3'(c), 1'b0} +: 2];
        red_d[c] = code[1] & ~(mute_amber & code[0]);
        grn_d[c] = code[0] & ~(mute_amber & code[1]);
      end
    end
  end

  // registered matrix drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.row_sel     <= '0;
      bus.col_red     <= '0;
      bus.col_grn     <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.row_sel     <= row_d;
      bus.col_red     <= red_d;
      bus.col_grn     <= grn_d;
      bus.frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scenario tasks checked against a frame-offset model.
// Model position t = cycles since the LOAD edge; row = t/R, lit when t%R >= B.
module tb_led_matrix_scanner;

  localparam int R  = 8;
  localparam int B  = 2;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_matrix_scanner_if bus ();

  led_matrix_scanner #(
    .ROW_CYCLES   (R),
    .BLANK_CYCLES (B),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         m_run;
  logic         m_fs;
  logic         m_blk;
  int           m_t;
  int           m_loads;
  logic [127:0] m_snap;

  logic [7:0] e_row;
  logic [7:0] e_red;
  logic [7:0] e_grn;
  int         mr;
  logic [1:0] mcode;

  // reference model: frame position and snapshot
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run   <= 1'b0;
      m_fs    <= 1'b0;
      m_blk   <= 1'b0;
      m_t     <= 0;
      m_loads <= 0;
      m_snap  <= '0;
    end else begin
      m_fs <= 1'b0;
      if (!m_run) begin
        if (bus.en) begin
          m_run   <= 1'b1;
          m_t     <= 0;
          m_snap  <= bus.field;
          m_fs    <= 1'b1;
          m_loads <= m_loads + 1;
`ifdef LMS_BLINK_EN
          m_blk   <= ((m_loads / BF) % 2) == 1;
`endif
        end
      end else if (!bus.en) begin
        m_run <= 1'b0;
      end else if (m_t == 8 * R - 1) begin
        m_run <= 1'b0;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // expected drive from the model's colour mapping
  always_comb begin
    e_row = '0;
    e_red = '0;
    e_grn = '0;
    mr    = 0;
    mcode = '0;
    if (m_run && (m_t % R) >= B) begin
      mr = m_t / R;
      e_row[mr] = 1'b1;
      for (int c = 0; c < 8; c++) begin
        mcode = m_snap[(mr * 8 + c) * 2 +: 2];
        case (mcode)
          2'b01: e_grn[c] = 1'b1;
          2'b10: e_red[c] = 1'b1;
          2'b11: begin
            e_red[c] = !m_blk;
            e_grn[c] = !m_blk;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic test_reset();
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.field = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !== 25'd0) begin
      errors++;
      $display("FAIL reset: got row=%h red=%h grn=%h fs=%b want all 0",
               bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !== 25'd0) begin
        errors++;
        $display("FAIL idle_en0: got row=%h red=%h grn=%h fs=%b want all 0",
                 bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start);
      end
    end
  endtask

  task automatic test_scan();
    logic [127:0] f;
    int first_fs;
    int second_fs;
    f = '0;
    f[27*2 +: 2] = 2'b10;
    f[36*2 +: 2] = 2'b10;
    f[28*2 +: 2] = 2'b01;
    f[35*2 +: 2] = 2'b01;
    bus.field = f;
    bus.en    = 1'b1;
    first_fs  = -1;
    second_fs = -1;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !==
          {e_row, e_red, e_grn, m_fs}) begin
        errors++;
        $display("FAIL scan k=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", k,
                 bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start,
                 e_row, e_red, e_grn, m_fs);
      end
      if (bus.frame_start === 1'b1) begin
        if (first_fs < 0) first_fs = k;
        else if (second_fs < 0) second_fs = k;
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (bus.row_sel !== ((k == 3) ? 8'h01 : 8'h00)) begin
          errors++;
          $display("FAIL scan_row0 k=%0d: got %h", k, bus.row_sel);
        end
      end
      if (k == 27) begin
        checks++;
        if ({bus.row_sel, bus.col_red, bus.col_grn} !== {8'h08, 8'h08, 8'h10}) begin
          errors++;
          $display("FAIL board_row3: got %h/%h/%h want 08/08/10",
                   bus.row_sel, bus.col_red, bus.col_grn);
        end
      end
      if (k == 35) begin
        checks++;
        if ({bus.row_sel, bus.col_red, bus.col_grn} !== {8'h10, 8'h10, 8'h08}) begin
          errors++;
          $display("FAIL board_row4: got %h/%h/%h want 10/10/08",
                   bus.row_sel, bus.col_red, bus.col_grn);
        end
      end
    end
    checks++;
    if (first_fs != 1 || second_fs - first_fs != 1 + 8 * R) begin
      errors++;
      $display("FAIL frame_period: got first=%0d second=%0d want 1 and %0d",
               first_fs, second_fs, 2 + 8 * R);
    end
  endtask

  task automatic test_tear();
    int n;
    int fs_seen;
    n = 0;
    while (!(m_run && m_t == 2 * R + B) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL tear_sync: row 2 not reached in %0d cycles", n);
    end
    bus.field = '1;
    fs_seen = 0;
    for (int k = 0; k < 2 * (1 + 8 * R); k++) begin
      @(negedge clk);
      checks++;
      if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !==
          {e_row, e_red, e_grn, m_fs}) begin
        errors++;
        $display("FAIL tear k=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", k,
                 bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start,
                 e_row, e_red, e_grn, m_fs);
      end
      if (m_fs) fs_seen++;
      if (fs_seen == 1 && e_row != 0 && !m_blk) begin
        checks++;
        if ({bus.col_red, bus.col_grn} !== 16'hFFFF) begin
          errors++;
          $display("FAIL tear_amber: got red=%h grn=%h want ff/ff",
                   bus.col_red, bus.col_grn);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    int n;
    n = 0;
    while (!(e_row == 8'h20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL endrop_sync: row 5 not reached in %0d cycles", n);
    end
    bus.en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !== 25'd0) begin
        errors++;
        $display("FAIL endrop_dark: got %h/%h/%h/%b want all 0",
                 bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start);
      end
    end
    bus.en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !==
          {e_row, e_red, e_grn, m_fs}) begin
        errors++;
        $display("FAIL enrise k=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", k,
                 bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start,
                 e_row, e_red, e_grn, m_fs);
      end
      if (k == 1 || k == 3) begin
        checks++;
        if ({bus.frame_start, bus.row_sel} !== ((k == 1) ? 9'h100 : 9'h001)) begin
          errors++;
          $display("FAIL enrise_restart k=%0d: got fs=%b row=%h", k,
                   bus.frame_start, bus.row_sel);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (e_row == 8'h00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !== 25'd0) begin
      errors++;
      $display("FAIL async_rst: got %h/%h/%h/%b want all 0",
               bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !==
          {e_row, e_red, e_grn, m_fs}) begin
        errors++;
        $display("FAIL after_rst k=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", k,
                 bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start,
                 e_row, e_red, e_grn, m_fs);
      end
      if (k == 1 || k == 66) begin
        checks++;
        if (bus.frame_start !== 1'b1) begin
          errors++;
          $display("FAIL after_rst_fs k=%0d: got %b want 1", k, bus.frame_start);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !==
          {e_row, e_red, e_grn, m_fs}) begin
        errors++;
        $display("FAIL random k=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", k,
                 bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start,
                 e_row, e_red, e_grn, m_fs);
      end
      if ($urandom_range(0, 7) == 0)
        bus.field = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (bus.en) begin
        if ($urandom_range(0, 149) == 0) bus.en = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        bus.en = 1'b1;
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 999) == 0) rst = 1'b1;
    end
    rst    = 1'b0;
    bus.en = 1'b1;
  endtask

`ifdef LMS_BLINK_EN
  task automatic test_blink();
    logic [127:0] f;
    int nf;
    f = '1;
    f[1:0] = 2'b01;
    rst = 1'b1;
    @(negedge clk);
    bus.field = f;
    bus.en    = 1'b1;
    rst       = 1'b0;
    nf = -1;
    for (int k = 0; k < 5 * (1 + 8 * R); k++) begin
      @(negedge clk);
      if (m_fs) nf++;
      checks++;
      if ({bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start} !==
          {e_row, e_red, e_grn, m_fs}) begin
        errors++;
        $display("FAIL blink k=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", k,
                 bus.row_sel, bus.col_red, bus.col_grn, bus.frame_start,
                 e_row, e_red, e_grn, m_fs);
      end
      if (e_row == 8'h02) begin
        checks++;
        if ({bus.col_red, bus.col_grn} !== (((nf / 2) % 2 == 0) ? 16'hFFFF : 16'h0000)) begin
          errors++;
          $display("FAIL blink_phase frame=%0d: got red=%h grn=%h", nf,
                   bus.col_red, bus.col_grn);
        end
      end
      if (e_row == 8'h01) begin
        checks++;
        if ({bus.col_red[0], bus.col_grn[0]} !== 2'b01) begin
          errors++;
          $display("FAIL blink_green frame=%0d: got red0=%b grn0=%b", nf,
                   bus.col_red[0], bus.col_grn[0]);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.en    = 1'b0;
    bus.field = '0;
    test_reset();
    test_scan();
    test_tear();
    test_en_drop();
    test_async_reset();
    test_random();
`ifdef LMS_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
